fp16_dot_pe: RTL and testbench

- Streaming binary16 multiply-accumulate processing element for the systolic/array datapath.
- Multiplies operand pairs, accumulates a run-time-configurable number of products, then presents one dot-product result under a valid/ready handshake.
- Adds the following over a free-running MAC PE:
  - registered product stage
  - input and output handshakes
  - programmable vector length
  - synchronous abort
  - a hold-until-consumed output register
- Arithmetic uses the codebase's combinational binary16 multiply and add units. Rounding, NaN, Inf and denormal behaviour are whatever those units produce.

---
 rtl/fp16_dot_pe.sv | 242 ++++++++++++++++++++++++
 tb/tb_fp16_dot_pe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_dot_pe.sv
// rtl/fp16_dot_pe.sv - streaming binary16 multiply-accumulate dot-product PE

// Combinational binary16 multiply.
// Denormal inputs are treated as zero and underflow flushes to signed zero.
// Rounding is round-to-nearest-even, and overflow gives a signed infinity.
module fp16_mul (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sy, rnd;
  logic [21:0] p;
  logic [10:0] m;
  logic [6:0]  e_raw;
  logic [4:0]  e_m1;
  logic [14:0] mag;

  assign a_nan  = (&a[14:10]) && (|a[9:0]);
  assign b_nan  = (&b[14:10]) && (|b[9:0]);
  assign a_inf  = (&a[14:10]) && !(|a[9:0]);
  assign b_inf  = (&b[14:10]) && !(|b[9:0]);
  assign a_zero = (a[14:10] == 5'd0);
  assign b_zero = (b[14:10] == 5'd0);

  // Significand product, normalise by at most one place, round, then select the special cases
  always_comb begin
    sy    = a[15] ^ b[15];
    p     = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e_raw = {2'b00, a[14:10]} + {2'b00, b[14:10]} + {6'd0, p[21]};
    if (p[21]) begin
      m   = p[21:11];
      rnd = p[10] & ((|p[9:0]) | p[11]);
    end else begin
      m   = p[20:10];
      rnd = p[9] & ((|p[8:0]) | p[10]);
    end
    // exponent field minus one; the hidden bit of m adds the one back, and a
    // rounding carry ripples into the exponent (up to infinity) for free
    e_m1 = e_raw[4:0] + 5'd16;
    mag  = {e_m1, 10'd0} + {4'd0, m} + {14'd0, rnd};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      y = 16'h7E00;
    else if (a_inf || b_inf)
      y = {sy, 5'h1F, 10'd0};
    else if (a_zero || b_zero)
      y = {sy, 15'd0};
    else if (e_raw >= 7'd46)
      y = {sy, 5'h1F, 10'd0};
    else if (e_raw <= 7'd15)
      y = {sy, 15'd0};
    else
      y = {sy, mag};
  end
endmodule

// Combinational binary16 add.
// Operands are aligned using three guard bits, and the sum is rounded to nearest-even.
// Exact cancellation gives +0. Denormal inputs and results are treated as zero.
module fp16_add (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] r;
    logic       f;
    r = 4'd0;
    f = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!f) begin
        if (v[i]) f = 1'b1;
        else r = r + 4'd1;
      end
    end
    return r;
  endfunction

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        swap, sl, ss, rnd;
  logic [4:0]  el, es, d, e_m1;
  logic [9:0]  ml, ms;
  logic [13:0] lg, sm, n;
  logic [27:0] sh;
  logic [14:0] sum, mag;
  logic [3:0]  lz;
  logic [6:0]  e;
  logic [10:0] m;

  assign a_nan  = (&a[14:10]) && (|a[9:0]);
  assign b_nan  = (&b[14:10]) && (|b[9:0]);
  assign a_inf  = (&a[14:10]) && !(|a[9:0]);
  assign b_inf  = (&b[14:10]) && !(|b[9:0]);
  assign a_zero = (a[14:10] == 5'd0);
  assign b_zero = (b[14:10] == 5'd0);

  // Order by magnitude, align the smaller operand with sticky, add or subtract, normalise, round
  always_comb begin
    sh   = 28'd0;
    swap = b[14:0] > a[14:0];
    {sl, el, ml} = swap ? b : a;
    {ss, es, ms} = swap ? a : b;
    d  = el - es;
    lg = {1'b1, ml, 3'b000};
    if (d > 5'd13) begin
      sm = 14'd1;
    end else begin
      sh = {1'b1, ms, 3'b000, 14'd0} >> d;
      sm = sh[27:14] | {13'd0, |sh[13:0]};
    end
    sum = (sl == ss) ? ({1'b0, lg} + {1'b0, sm}) : ({1'b0, lg} - {1'b0, sm});
    lz  = lzc14(sum[13:0]);
    if (sum[14]) begin
      n = {sum[14:2], |sum[1:0]};
      e = {2'b00, el} + 7'd1;
    end else begin
      n = sum[13:0] << lz;
      e = {2'b00, el} - {3'b000, lz};
    end
    m    = n[13:3];
    rnd  = n[2] & ((|n[1:0]) | n[3]);
    e_m1 = e[4:0] - 5'd1;
    mag  = {e_m1, 10'd0} + {4'd0, m} + {14'd0, rnd};
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
      y = 16'h7E00;
    else if (a_inf)
      y = a;
    else if (b_inf)
      y = b;
    else if (a_zero && b_zero)
      y = {a[15] & b[15], 15'd0};
    else if (a_zero)
      y = b;
    else if (b_zero)
      y = a;
    else if (sum == 15'd0)
      y = 16'h0000;
    else if (!sum[14] && ({1'b0, lz} >= el))
      y = {sl, 15'd0};
    else if (e >= 7'd31)
      y = {sl, 5'h1F, 10'd0};
    else
      y = {sl, mag};
  end
endmodule

// Dot-product PE.
// Products are registered, then accumulated one edge later. A vector ends with
// one DRAIN cycle that folds in the last product, and the result is then held
// in DONE until the consumer takes it.
module fp16_dot_pe #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_LEN    = 64,
  parameter int LEN_W      = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clear,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] float_a,
  input  logic [DATA_WIDTH-1:0] float_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);
  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  state_t                state;
  logic [DATA_WIDTH-1:0] acc, prod_r, mul_y, add_y;
  logic                  prod_v, hs, last;
  logic [LEN_W-1:0]      count, count_nxt, len_r, cfg_sat, eff_len;

  fp16_mul u_mul (.a(float_a), .b(float_b), .y(mul_y));
  fp16_add u_add (.a(prod_r),  .b(acc),     .y(add_y));

  // A zero or oversize length selects the maximum. The first pair of a vector
  // uses the freshly sampled length, so a one-pair vector ends on that pair.
  assign cfg_sat   = ((cfg_len == '0) || (cfg_len > MAX_L)) ? MAX_L : cfg_len;
  assign eff_len   = (count == '0) ? cfg_sat : len_r;
  assign count_nxt = count + LEN_W'(1);
  assign in_ready  = (state == ACCUM) && !clear && (count < len_r);
  assign hs        = in_valid && in_ready;
  assign last      = hs && (count_nxt == eff_len);
  assign out_valid = (state == DONE);
  assign result    = acc;
  assign busy      = (count != '0) || (state != ACCUM);

  // Control FSM: accept pairs, drain the final product, hold the result until consumed
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= ACCUM;
      count  <= '0;
      len_r  <= MAX_L;
      prod_v <= 1'b0;
      prod_r <= '0;
    end else if (clear) begin
      state  <= ACCUM;
      count  <= '0;
      prod_v <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          prod_v <= hs;
          if (hs) begin
            prod_r <= mul_y;
            count  <= count_nxt;
            if (count == '0) len_r <= cfg_sat;
            if (last) state <= DRAIN;
          end
        end
        DRAIN: begin
          prod_v <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          prod_v <= 1'b0;
          if (out_ready) begin
            count <= '0;
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // Accumulator: starts each vector from +0 and folds in every registered product
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      acc <= '0;
    else if (clear)
      acc <= '0;
    else if ((state == DONE) && out_ready)
      acc <= '0;
    else if (prod_v)
      acc <= add_y;
  end
endmodule

// File: tb/tb_fp16_dot_pe.sv
// tb/tb_fp16_dot_pe.sv - scoreboard bench for fp16_dot_pe
module tb_fp16_dot_pe;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clear = 1'b0;
  logic [6:0]  cfg_len = 7'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] float_a = 16'h0;
  logic [15:0] float_b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        busy;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          dummy;
  int          c_a, c_b;
  logic [15:0] exp_q[$];

  fp16_dot_pe #(.DATA_WIDTH(16), .MAX_LEN(4), .LEN_W(7)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .float_a(float_a), .float_b(float_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      else check("result", {16'd0, result}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, output int acc_cyc);
    int waited;
    float_a  = a;
    float_b  = b;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic vec_rep(input logic [6:0] len, input logic [15:0] a, input logic [15:0] b,
                         input int n, input bit gap, input logic [15:0] exp, output int first);
    int c;
    cfg_len = len;
    exp_q.push_back(exp);
    for (int i = 0; i < n; i++) begin
      send(a, b, c);
      if (i == 0) first = c;
      if (gap && i < n - 1) begin
        @(posedge clk);
        #1;
      end
    end
    check("drain_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("latency_t2", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", {16'd0, result}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // basic vector 1*2 + 2*2 + 3*1 + 0.5*2 = 10, under backpressure
    out_ready = 1'b0;
    cfg_len   = 7'd4;
    exp_q.push_back(16'h4900);
    send(16'h3C00, 16'h4000, dummy);
    send(16'h4000, 16'h4000, dummy);
    send(16'h4200, 16'h3C00, dummy);
    send(16'h3800, 16'h4000, dummy);
    check("drain_in_ready", {31'd0, in_ready}, 32'd0);
    check("drain_no_valid", {31'd0, out_valid}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    check("basic_latency", {31'd0, out_valid}, 32'd1);
    check("basic_result", {16'd0, result}, 32'h4900);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_result", {16'd0, result}, 32'h4900);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_consume", {31'd0, in_ready}, 32'd1);
    check("valid_after_consume", {31'd0, out_valid}, 32'd0);
    check("busy_after_consume", {31'd0, busy}, 32'd0);

    // -6 + 6 cancels to +0
    cfg_len = 7'd2;
    exp_q.push_back(16'h0000);
    send(16'hC000, 16'h4200, dummy);
    send(16'h4400, 16'h3E00, dummy);
    repeat (2) @(posedge clk);
    #1;

    // -2 + 1 = -1
    cfg_len = 7'd2;
    exp_q.push_back(16'hBC00);
    send(16'hBC00, 16'h4000, dummy);
    send(16'h3C00, 16'h3C00, dummy);
    repeat (2) @(posedge clk);
    #1;

    // gapped input, single pair, zero and oversize length
    vec_rep(7'd3, 16'h3C00, 16'h3C00, 3, 1'b1, 16'h4200, dummy);
    vec_rep(7'd1, 16'h4000, 16'h4200, 1, 1'b0, 16'h4600, dummy);
    vec_rep(7'd0, 16'h3C00, 16'h3C00, 4, 1'b0, 16'h4400, dummy);
    vec_rep(7'd9, 16'h3C00, 16'h4000, 4, 1'b0, 16'h4800, dummy);

    // cfg_len change mid-vector is ignored
    cfg_len = 7'd3;
    exp_q.push_back(16'h4600);
    send(16'h3C00, 16'h4000, dummy);
    cfg_len = 7'd1;
    send(16'h3C00, 16'h4000, dummy);
    check("midcfg_in_ready", {31'd0, in_ready}, 32'd1);
    send(16'h3C00, 16'h4000, dummy);
    check("midcfg_drain", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // abort after 2 of 4 pairs, then a fresh vector
    cfg_len = 7'd4;
    send(16'h4000, 16'h4000, dummy);
    send(16'h4000, 16'h4000, dummy);
    float_a  = 16'h4400;
    float_b  = 16'h4400;
    in_valid = 1'b1;
    clear    = 1'b1;
    @(negedge clk);
    check("clear_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_busy", {31'd0, busy}, 32'd0);
    check("clear_out_valid", {31'd0, out_valid}, 32'd0);
    vec_rep(7'd2, 16'h3C00, 16'h3C00, 2, 1'b0, 16'h4000, dummy);

    // async reset while in DRAIN
    cfg_len = 7'd1;
    send(16'h4000, 16'h4000, dummy);
    #2 rstn = 1'b0;
    #1;
    check("rst_drain_busy", {31'd0, busy}, 32'd0);
    check("rst_drain_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_drain_out_valid", {31'd0, out_valid}, 32'd0);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    // async reset while in DONE
    out_ready = 1'b0;
    cfg_len   = 7'd1;
    send(16'h4000, 16'h4000, dummy);
    @(posedge clk);
    #1;
    check("done_before_rst", {31'd0, out_valid}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_done_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done_result", {16'd0, result}, 32'h0);
    check("rst_done_busy", {31'd0, busy}, 32'd0);
    #1 rstn = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vec_rep(7'd2, 16'h3C00, 16'h3C00, 2, 1'b0, 16'h4000, dummy);

    // back-to-back vectors with out_ready high: period len+2
    vec_rep(7'd2, 16'h4000, 16'h4000, 2, 1'b0, 16'h4800, c_a);
    vec_rep(7'd3, 16'h3C00, 16'h4000, 3, 1'b0, 16'h4600, c_b);
    check("period_len2", c_b - c_a, 32'd4);
    vec_rep(7'd1, 16'h3C00, 16'h3C00, 1, 1'b0, 16'h3C00, c_a);
    check("period_len3", c_a - c_b, 32'd5);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
